// File: rtl/neuron_timestep_sequencer_pkg.sv
// Shared definitions for the timestep sequencer: FSM encoding, datapath
// width helpers and the decay (shift) select encoding.
package neuron_timestep_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EVAL = 2'd1,
      ST_DONE = 2'd2
   } seq_state_e;

   function automatic int data_width(input int n_stage);
      return int'(32'd1 << n_stage);
   endfunction

   function automatic int pot_width(input int n_stage);
      return n_stage + 32'sd2;
   endfunction

   // Decay select: shift k gives beta = 1 - 2**-k, with 0 meaning no decay.
   localparam logic [2:0] SHIFT_BETA_1_00000 = 3'd0;
   localparam logic [2:0] SHIFT_BETA_0_50000 = 3'd1;
   localparam logic [2:0] SHIFT_BETA_0_75000 = 3'd2;
   localparam logic [2:0] SHIFT_BETA_0_87500 = 3'd3;
   localparam logic [2:0] SHIFT_BETA_0_93750 = 3'd4;
   localparam logic [2:0] SHIFT_BETA_0_96875 = 3'd5;
   localparam logic [2:0] SHIFT_BETA_0_98438 = 3'd6;
   localparam logic [2:0] SHIFT_BETA_0_99219 = 3'd7;

endpackage

// File: rtl/neuron_timestep_sequencer_state_ram.sv
// Per-neuron state store: one row of {spike bit, potential} per neuron,
// asynchronous read, one synchronous write port and a bulk clear.
module neuron_state_ram #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 5,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_r [DEPTH];

   // Row storage with reset, bulk clear and single write port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (clr) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/neuron_timestep_sequencer.sv
// Timestep engine: walks every logical neuron once per start through the
// shared external neuron datapath and publishes the resulting spike vector.
module neuron_timestep_sequencer
   import neuron_timestep_sequencer_pkg::*;
#(
   parameter int N_STAGE   = 2,
   parameter int N_NEURONS = 4,
   localparam int W = data_width(N_STAGE),
   localparam int P = pot_width(N_STAGE),
   localparam int A = $clog2(N_NEURONS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 clear_state,
   input  logic [W-1:0]         x_in,
   input  logic [2:0]           shift,
   input  logic [P-1:0]         minus_teta,
   input  logic                 cfg_we,
   input  logic [A-1:0]         cfg_addr,
   input  logic [W-1:0]         cfg_wdata,
   output logic [W-1:0]         dp_w,
   output logic [W-1:0]         dp_x,
   output logic [2:0]           dp_shift,
   output logic [P-1:0]         dp_minus_teta,
   output logic [P-1:0]         dp_previus_u,
   output logic                 dp_was_spike,
   input  logic [P-1:0]         dp_u_out,
   input  logic                 dp_is_spike,
   output logic                 busy,
   output logic                 done,
   output logic [N_NEURONS-1:0] spikes_out
);

   localparam logic [A-1:0] IDX_LAST = A'(N_NEURONS - 1);
   localparam logic [A:0]   N_ROWS   = (A+1)'(N_NEURONS);

   seq_state_e           state_r;
   seq_state_e           state_nxt_s;
   logic [A-1:0]         idx_r;
   logic [W-1:0]         x_r;
   logic [2:0]           shift_r;
   logic [P-1:0]         mteta_r;
   logic [N_NEURONS-1:0] spk_next_r;
   logic [N_NEURONS-1:0] spk_merged_s;
   logic [N_NEURONS-1:0] spikes_out_r;
   logic                 done_r;
   logic                 busy_r;
   logic [W-1:0]         weight_r [N_NEURONS];
   logic [P:0]           row_s;
   logic                 is_idle_s;
   logic                 is_eval_s;
   logic                 last_s;
   logic                 wr_ok_s;

   assign is_idle_s = (state_r == ST_IDLE);
   assign is_eval_s = (state_r == ST_EVAL);
   assign last_s    = is_eval_s && (idx_r == IDX_LAST);
   assign wr_ok_s   = ({1'b0, cfg_addr} < N_ROWS);

   // Each row is read exactly once per timestep, so committing the new spike
   // bit at its own evaluation is indistinguishable from a bulk update at DONE.
   neuron_state_ram #(
      .DEPTH (N_NEURONS),
      .WIDTH (P + 1)
   ) u_state_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (is_idle_s && clear_state),
      .we    (is_eval_s),
      .waddr (idx_r),
      .wdata ({dp_is_spike, dp_u_out}),
      .raddr (idx_r),
      .rdata (row_s)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nxt_s = ST_EVAL;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_EVAL: begin
            if (idx_r == IDX_LAST) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_EVAL;
            end
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Spike vector of the current timestep including the neuron now evaluated
   always_comb begin
      spk_merged_s         = spk_next_r;
      spk_merged_s[idx_r]  = dp_is_spike;
   end

   // Timestep operands, neuron index and spike collection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_r        <= '0;
         x_r          <= '0;
         shift_r      <= '0;
         mteta_r      <= '0;
         spk_next_r   <= '0;
         spikes_out_r <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  x_r     <= x_in;
                  shift_r <= shift;
                  mteta_r <= minus_teta;
                  idx_r   <= '0;
               end
            end
            ST_EVAL: begin
               spk_next_r <= spk_merged_s;
               idx_r      <= idx_r + A'(1'b1);
               if (last_s) begin
                  spikes_out_r <= spk_merged_s;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Weight store: writes only in IDLE, and a same-cycle start wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_NEURONS; i++) begin
            weight_r[i] <= '0;
         end
      end else if (is_idle_s && !start && cfg_we && wr_ok_s) begin
         weight_r[cfg_addr] <= cfg_wdata;
      end
   end

   // Status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_r <= 1'b0;
         busy_r <= 1'b0;
      end else begin
         done_r <= last_s;
         busy_r <= (state_nxt_s != ST_IDLE);
      end
   end

   // Datapath operand drive, quiet outside EVAL
   always_comb begin
      dp_w          = '0;
      dp_x          = '0;
      dp_shift      = '0;
      dp_minus_teta = '0;
      dp_previus_u  = '0;
      dp_was_spike  = 1'b0;
      if (is_eval_s) begin
         dp_w          = weight_r[idx_r];
         dp_x          = x_r;
         dp_shift      = shift_r;
         dp_minus_teta = mteta_r;
         dp_previus_u  = row_s[P-1:0];
         dp_was_spike  = row_s[P];
      end else begin
         dp_w          = '0;
         dp_x          = '0;
         dp_shift      = '0;
         dp_minus_teta = '0;
         dp_previus_u  = '0;
         dp_was_spike  = 1'b0;
      end
   end

   assign busy       = busy_r;
   assign done       = done_r;
   assign spikes_out = spikes_out_r;

endmodule

// File: tb/tb_neuron_timestep_sequencer.sv
// Self-checking bench: behavioural neuron on the dp_* bus and a per-neuron
// reference of weights, potentials and spikes updated once per timestep.
module tb_neuron_timestep_sequencer;

   localparam int N_STAGE = 2;
   localparam int N       = 4;
   localparam int W       = 4;
   localparam int P       = 4;
   localparam int A       = 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         clear_state;
   logic [W-1:0] x_in;
   logic [2:0]   shift;
   logic [P-1:0] minus_teta;
   logic         cfg_we;
   logic [A-1:0] cfg_addr;
   logic [W-1:0] cfg_wdata;
   logic [W-1:0] dp_w;
   logic [W-1:0] dp_x;
   logic [2:0]   dp_shift;
   logic [P-1:0] dp_minus_teta;
   logic [P-1:0] dp_previus_u;
   logic         dp_was_spike;
   logic [P-1:0] dp_u_out;
   logic         dp_is_spike;
   logic         busy;
   logic         done;
   logic [N-1:0] spikes_out;

   int errors = 0;
   int checks = 0;

   logic [W-1:0] ref_w   [N];
   logic [P-1:0] ref_u   [N];
   logic         ref_spk [N];
   logic [N-1:0] ref_out;
   logic [N-1:0] obs_was;
   logic [P-1:0] obs_u_or;

   always #5 clk = ~clk;

   neuron_timestep_sequencer #(.N_STAGE(N_STAGE), .N_NEURONS(N)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .clear_state(clear_state),
      .x_in(x_in), .shift(shift), .minus_teta(minus_teta),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .dp_w(dp_w), .dp_x(dp_x), .dp_shift(dp_shift), .dp_minus_teta(dp_minus_teta),
      .dp_previus_u(dp_previus_u), .dp_was_spike(dp_was_spike),
      .dp_u_out(dp_u_out), .dp_is_spike(dp_is_spike),
      .busy(busy), .done(done), .spikes_out(spikes_out)
   );

   // Leaky integrate-and-fire neuron: reset after a spike, decay by shift,
   // add matched inputs, saturate, fire when u + minus_teta wraps.
   function automatic logic [P:0] nmodel(input logic [W-1:0] w, input logic [W-1:0] x,
                                         input logic [2:0] sh, input logic [P-1:0] mt,
                                         input logic [P-1:0] prev, input logic was);
      int   base;
      int   s;
      logic spk;
      base = was ? 0 : int'(prev);
      if (sh != 3'd0) base = base - (base >> sh);
      s = base + $countones(w & x);
      if (s > (2**P - 1)) s = 2**P - 1;
      spk = (mt != '0) && ((s + int'(mt)) >= 2**P);
      return {spk, s[P-1:0]};
   endfunction

   assign {dp_is_spike, dp_u_out} = nmodel(dp_w, dp_x, dp_shift, dp_minus_teta,
                                           dp_previus_u, dp_was_spike);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic ref_reset();
      for (int k = 0; k < N; k++) begin
         ref_w[k] = '0; ref_u[k] = '0; ref_spk[k] = 1'b0;
      end
      ref_out = '0;
   endtask

   task automatic ref_step(input logic [W-1:0] x, input logic [2:0] sh, input logic [P-1:0] mt);
      logic [P:0] r;
      for (int k = 0; k < N; k++) begin
         r = nmodel(ref_w[k], x, sh, mt, ref_u[k], ref_spk[k]);
         ref_u[k]   = r[P-1:0];
         ref_spk[k] = r[P];
         ref_out[k] = r[P];
      end
   endtask

   task automatic wr(input int a, input logic [W-1:0] d);
      cfg_we = 1'b1; cfg_addr = A'(a); cfg_wdata = d;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      ref_w[a] = d;
      @(negedge clk);
   endtask

   task automatic clr();
      clear_state = 1'b1;
      @(posedge clk); #1;
      clear_state = 1'b0;
      for (int k = 0; k < N; k++) begin
         ref_u[k] = '0; ref_spk[k] = 1'b0;
      end
      @(negedge clk);
   endtask

   // One timestep, checked cycle by cycle; optionally with a coincident
   // clear or weight write, and with ignored pokes while busy.
   task automatic run_ts(input logic [W-1:0] x, input logic [2:0] sh, input logic [P-1:0] mt,
                         input bit with_clear, input bit with_wr, input bit poke);
      if (with_clear) begin
         for (int k = 0; k < N; k++) begin
            ref_u[k] = '0; ref_spk[k] = 1'b0;
         end
      end
      x_in = x; shift = sh; minus_teta = mt; start = 1'b1;
      clear_state = with_clear; cfg_we = with_wr;
      cfg_addr = A'($urandom_range(0, N-1)); cfg_wdata = W'($urandom);
      @(posedge clk); #1;
      start = 1'b0; clear_state = 1'b0; cfg_we = 1'b0;
      obs_was = '0; obs_u_or = '0;
      for (int k = 0; k < N; k++) begin
         if (poke) begin
            start = 1'b1; clear_state = 1'b1; cfg_we = 1'b1;
            cfg_addr = A'($urandom_range(0, N-1)); cfg_wdata = W'($urandom);
            x_in = W'($urandom);
         end
         @(negedge clk);
         chk($sformatf("dp_w[%0d]", k), 32'(dp_w), 32'(ref_w[k]));
         chk($sformatf("dp_x[%0d]", k), 32'(dp_x), 32'(x));
         chk($sformatf("dp_shift[%0d]", k), 32'(dp_shift), 32'(sh));
         chk($sformatf("dp_minus_teta[%0d]", k), 32'(dp_minus_teta), 32'(mt));
         chk($sformatf("dp_previus_u[%0d]", k), 32'(dp_previus_u), 32'(ref_u[k]));
         chk($sformatf("dp_was_spike[%0d]", k), 32'(dp_was_spike), 32'(ref_spk[k]));
         chk($sformatf("busy_eval[%0d]", k), 32'(busy), 32'd1);
         chk($sformatf("done_eval[%0d]", k), 32'(done), 32'd0);
         obs_was[k] = dp_was_spike;
         obs_u_or   = obs_u_or | dp_previus_u;
      end
      start = 1'b0; clear_state = 1'b0; cfg_we = 1'b0;
      ref_step(x, sh, mt);
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'd1);
      chk("busy_done", 32'(busy), 32'd1);
      chk("spikes_out", 32'(spikes_out), 32'(ref_out));
      @(negedge clk);
      chk("done_after", 32'(done), 32'd0);
      chk("busy_after", 32'(busy), 32'd0);
      chk("dp_w_idle", 32'(dp_w), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [W-1:0] hx;
      logic [2:0]   hs;
      logic [P-1:0] hm;
      rst_n = 1'b0; start = 1'b0; clear_state = 1'b0; x_in = '0; shift = '0;
      minus_teta = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      ref_reset();
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_spikes", 32'(spikes_out), 32'd0);
      chk("rst_dp_w", 32'(dp_w), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Weight ramp with threshold so only the two heaviest neurons fire
      wr(0, 4'h1); wr(1, 4'h3); wr(2, 4'h7); wr(3, 4'hF);
      run_ts(4'hF, 3'd0, 4'd13, 1'b0, 1'b0, 1'b0);
      chk("threshold_spikes", 32'(spikes_out), 32'(4'b1100));
      run_ts(4'hF, 3'd0, 4'd13, 1'b0, 1'b0, 1'b0);
      chk("was_spike_vec", 32'(obs_was), 32'(4'b1100));

      // start with cfg_we together, then busy pokes; readback via dp_w
      run_ts(4'hA, 3'd1, 4'd12, 1'b0, 1'b1, 1'b0);
      run_ts(4'h5, 3'd2, 4'd10, 1'b0, 1'b0, 1'b1);
      run_ts(4'h3, 3'd0, 4'd14, 1'b0, 1'b0, 1'b0);

      // Clear in IDLE after accumulation, then clear coinciding with start
      clr();
      run_ts(4'hF, 3'd0, 4'd13, 1'b0, 1'b0, 1'b0);
      chk("clear_prev_u", 32'(obs_u_or), 32'd0);
      chk("clear_was", 32'(obs_was), 32'd0);
      run_ts(4'h7, 3'd0, 4'd11, 1'b1, 1'b0, 1'b0);
      chk("clear_start_prev_u", 32'(obs_u_or), 32'd0);

      // start held high: one done every six cycles
      hx = W'($urandom); hs = 3'($urandom_range(0, 7)); hm = P'($urandom);
      x_in = hx; shift = hs; minus_teta = hm; start = 1'b1;
      for (int c = 1; c <= 18; c++) begin
         @(negedge clk);
         chk($sformatf("held_done_c%0d", c), 32'(done), ((c % 6) == 5) ? 32'd1 : 32'd0);
      end
      start = 1'b0;
      for (int t = 0; t < 3; t++) ref_step(hx, hs, hm);
      @(negedge clk);

      // Randomized timesteps
      for (int t = 0; t < 8; t++) begin
         if ($urandom_range(0, 1) == 1) wr(int'($urandom_range(0, N-1)), W'($urandom));
         run_ts(W'($urandom), 3'($urandom_range(0, 7)), P'($urandom),
                $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end

      // Reset in the middle of EVAL at idx 2
      x_in = 4'hF; shift = 3'd0; minus_teta = 4'd13; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_spikes", 32'(spikes_out), 32'd0);
      ref_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk($sformatf("midrst_no_done_%0d", c), 32'(done), 32'd0);
      end
      run_ts(4'hF, 3'd0, 4'd13, 1'b0, 1'b0, 1'b0);
      chk("midrst_prev_u", 32'(obs_u_or), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
